data_mem_ctrl: RTL and testbench

- Data-side memory controller directly downstream of the reorder buffer's commit stage.
- Accepts committed stores from the reorder buffer (single-cycle request pulse) and speculative loads from the load buffer (level-held request).
- Serialises each access onto the byte-wide RAM port and returns a one-cycle completion pulse to the requester.
- On a pipeline flush it aborts loads only; committed stores always complete.

---
 rtl/data_mem_ctrl_pkg.sv | 27 ++
 rtl/data_mem_ctrl_load_extend.sv | 22 ++
 rtl/data_mem_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_ctrl_pkg.sv
// Shared constants for the data-side memory controller: size codes, states,
// RAM port width.
package data_mem_ctrl_pkg;

   localparam int unsigned MEM_WIDTH = 8;

   localparam logic [2:0] WIDTH_B = 3'b001;
   localparam logic [2:0] WIDTH_H = 3'b010;
   localparam logic [2:0] WIDTH_W = 3'b100;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_STORE = 2'd1,
      S_LOAD  = 2'd2,
      S_LWAIT = 2'd3
   } state_e;

   // Number of RAM beats for a size code; unknown codes are treated as a word.
   function automatic logic [2:0] width_bytes(input logic [2:0] code);
      case (code)
         WIDTH_B: return 3'd1;
         WIDTH_H: return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/data_mem_ctrl_load_extend.sv
// Sign/zero extension of an assembled 1/2/4-byte load result.
module data_mem_ctrl_load_extend
   import data_mem_ctrl_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] raw,
   input  logic [2:0]            width,
   input  logic                  sgn,
   output logic [DATA_WIDTH-1:0] ext_c
);

   always_comb begin
      ext_c = raw;
      case (width)
         WIDTH_B: ext_c = {{(DATA_WIDTH-8){sgn & raw[7]}},   raw[7:0]};
         WIDTH_H: ext_c = {{(DATA_WIDTH-16){sgn & raw[15]}}, raw[15:0]};
         default: ext_c = raw;
      endcase
   end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller: serialises committed stores and speculative loads
// onto a byte-wide RAM port; a flush aborts loads but never stores.
module data_mem_ctrl
   import data_mem_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  rdy_in,
   input  logic                  rob_rst_in,
   input  logic                  rob_datactrl_en_in,
   input  logic [ADDR_WIDTH-1:0] rob_datactrl_addr_in,
   input  logic [2:0]            rob_datactrl_width_in,
   input  logic [DATA_WIDTH-1:0] rob_datactrl_data_in,
   output logic                  datactrl_rob_en_out,
   input  logic                  lbuffer_datactrl_en_in,
   input  logic [ADDR_WIDTH-1:0] lbuffer_datactrl_addr_in,
   input  logic [2:0]            lbuffer_datactrl_width_in,
   input  logic                  lbuffer_datactrl_signed_in,
   output logic                  datactrl_lbuffer_en_out,
   output logic [DATA_WIDTH-1:0] datactrl_lbuffer_data_out,
   input  logic [7:0]            mem_din,
   output logic [7:0]            mem_dout,
   output logic [ADDR_WIDTH-1:0] mem_a,
   output logic                  mem_wr
);

   state_e                state_q, state_d;
   logic [2:0]            cnt_q, cnt_d;

   logic                  st_vld;
   logic [ADDR_WIDTH-1:0] st_addr;
   logic [2:0]            st_width;
   logic [DATA_WIDTH-1:0] st_data;
   logic                  st_clr;

   logic [ADDR_WIDTH-1:0] ld_addr;
   logic [2:0]            ld_width;
   logic                  ld_sgn;
   logic [DATA_WIDTH-1:0] ld_res, res_d, ld_fin, ld_ext_c;
   logic                  ld_accept;

   logic [ADDR_WIDTH-1:0] mem_a_d;
   logic [7:0]            mem_dout_d;
   logic                  mem_wr_d, rob_done_d, lb_done_d;
   logic [DATA_WIDTH-1:0] lb_data_d;

   logic [2:0]            st_n, ld_n;

   assign st_n = width_bytes(st_width);
   assign ld_n = width_bytes(ld_width);

   // Final load word: earlier bytes from ld_res, last byte straight off mem_din.
   always_comb begin
      ld_fin = ld_res;
      ld_fin[{2'(ld_n - 3'd1), 3'b000} +: MEM_WIDTH] = mem_din;
   end

   data_mem_ctrl_load_extend #(.DATA_WIDTH(DATA_WIDTH)) u_load_extend (
      .raw   (ld_fin),
      .width (ld_width),
      .sgn   (ld_sgn),
      .ext_c (ld_ext_c)
   );

   // Next state and next registered outputs.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      st_clr     = 1'b0;
      ld_accept  = 1'b0;
      mem_a_d    = mem_a;
      mem_dout_d = '0;
      mem_wr_d   = 1'b0;
      rob_done_d = 1'b0;
      lb_done_d  = 1'b0;
      lb_data_d  = datactrl_lbuffer_data_out;
      res_d      = ld_res;
      case (state_q)
         S_IDLE: begin
            cnt_d = 3'd0;
            if (st_vld || rob_datactrl_en_in) begin
               state_d = S_STORE;
            end else if (lbuffer_datactrl_en_in && !rob_rst_in) begin
               state_d   = S_LOAD;
               ld_accept = 1'b1;
            end
         end
         S_STORE: begin
            if (cnt_q == st_n) begin
               // Re-arbitrate on the done edge so back-to-back requests see no bubble.
               rob_done_d = 1'b1;
               st_clr     = 1'b1;
               cnt_d      = 3'd0;
               if (rob_datactrl_en_in) begin
                  state_d = S_STORE;
               end else if (lbuffer_datactrl_en_in && !rob_rst_in) begin
                  state_d   = S_LOAD;
                  ld_accept = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               mem_a_d    = st_addr + ADDR_WIDTH'(cnt_q);
               mem_dout_d = st_data[{cnt_q[1:0], 3'b000} +: MEM_WIDTH];
               mem_wr_d   = 1'b1;
               cnt_d      = cnt_q + 3'd1;
            end
         end
         S_LOAD: begin
            if (rob_rst_in) begin
               state_d = S_IDLE;
               cnt_d   = 3'd0;
            end else begin
               // Read data trails the issued address by two edges.
               if (cnt_q >= 3'd2) begin
                  res_d[{2'(cnt_q - 3'd2), 3'b000} +: MEM_WIDTH] = mem_din;
               end
               if (cnt_q < ld_n) begin
                  mem_a_d = ld_addr + ADDR_WIDTH'(cnt_q);
                  cnt_d   = cnt_q + 3'd1;
               end else begin
                  state_d = S_LWAIT;
               end
            end
         end
         S_LWAIT: begin
            cnt_d = 3'd0;
            if (rob_rst_in) begin
               state_d = S_IDLE;
            end else begin
               res_d     = ld_fin;
               lb_data_d = ld_ext_c;
               lb_done_d = 1'b1;
               // The load buffer still holds its request this cycle; only a store may start.
               state_d   = (st_vld || rob_datactrl_en_in) ? S_STORE : S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q                   <= S_IDLE;
         cnt_q                     <= 3'd0;
         ld_res                    <= '0;
         mem_a                     <= '0;
         mem_dout                  <= '0;
         mem_wr                    <= 1'b0;
         datactrl_rob_en_out       <= 1'b0;
         datactrl_lbuffer_en_out   <= 1'b0;
         datactrl_lbuffer_data_out <= '0;
      end else if (rdy_in) begin
         state_q                   <= state_d;
         cnt_q                     <= cnt_d;
         ld_res                    <= res_d;
         mem_a                     <= mem_a_d;
         mem_dout                  <= mem_dout_d;
         mem_wr                    <= mem_wr_d;
         datactrl_rob_en_out       <= rob_done_d;
         datactrl_lbuffer_en_out   <= lb_done_d;
         datactrl_lbuffer_data_out <= lb_data_d;
      end else begin
         mem_wr   <= 1'b0;
         mem_dout <= '0;
      end
   end

   // One-entry store latch; a new capture takes priority over the clear.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         st_vld   <= 1'b0;
         st_addr  <= '0;
         st_width <= '0;
         st_data  <= '0;
      end else if (rdy_in) begin
         if (rob_datactrl_en_in) begin
            st_vld   <= 1'b1;
            st_addr  <= rob_datactrl_addr_in;
            st_width <= rob_datactrl_width_in;
            st_data  <= rob_datactrl_data_in;
         end else if (st_clr) begin
            st_vld <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         ld_addr  <= '0;
         ld_width <= '0;
         ld_sgn   <= 1'b0;
      end else if (rdy_in && ld_accept) begin
         ld_addr  <= lbuffer_datactrl_addr_in;
         ld_width <= lbuffer_datactrl_width_in;
         ld_sgn   <= lbuffer_datactrl_signed_in;
      end
   end

   a_single_store: assert property (@(posedge clk_in) disable iff (!rst_in)
      (rdy_in && rob_datactrl_en_in) |-> (!st_vld || st_clr));

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed, table-driven bench for data_mem_ctrl with a byte-wide RAM model.
module tb_data_mem_ctrl;

   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in, rob_rst_in;
   logic        rob_en, rob_done, lb_en, lb_sgn, lb_done, mem_wr;
   logic [31:0] rob_addr, rob_data, lb_addr, lb_data, mem_a;
   logic [2:0]  rob_width, lb_width;
   logic [7:0]  mem_din, mem_dout;

   int checks = 0;
   int errors = 0;

   always #5 clk_in = ~clk_in;

   data_mem_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk_in                     (clk_in),
      .rst_in                     (rst_in),
      .rdy_in                     (rdy_in),
      .rob_rst_in                 (rob_rst_in),
      .rob_datactrl_en_in         (rob_en),
      .rob_datactrl_addr_in       (rob_addr),
      .rob_datactrl_width_in      (rob_width),
      .rob_datactrl_data_in       (rob_data),
      .datactrl_rob_en_out        (rob_done),
      .lbuffer_datactrl_en_in     (lb_en),
      .lbuffer_datactrl_addr_in   (lb_addr),
      .lbuffer_datactrl_width_in  (lb_width),
      .lbuffer_datactrl_signed_in (lb_sgn),
      .datactrl_lbuffer_en_out    (lb_done),
      .datactrl_lbuffer_data_out  (lb_data),
      .mem_din                    (mem_din),
      .mem_dout                   (mem_dout),
      .mem_a                      (mem_a),
      .mem_wr                     (mem_wr)
   );

   // 4 KiB RAM, registered read: data appears the cycle after its address.
   logic [7:0] ram [0:4095];
   always @(posedge clk_in) begin
      if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
      mem_din <= ram[mem_a[11:0]];
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %h required %h", nm, act, exp);
      end
   endtask

   task automatic do_store(input string nm, input logic [31:0] addr, input logic [2:0] w,
                           input logic [31:0] data, input int lat);
      int n, got;
      logic [31:0] d;
      n = (w == 3'b001) ? 1 : (w == 3'b010) ? 2 : 4;
      rob_en = 1'b1; rob_addr = addr; rob_width = w; rob_data = data;
      @(posedge clk_in); #1;
      rob_en = 1'b0;
      got = -1;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk_in); #1;
         if (c <= n) begin
            d = data >> (8 * (c - 1));
            check({nm, " wr"},   {31'b0, mem_wr}, 32'd1);
            check({nm, " a"},    mem_a, addr + 32'(c - 1));
            check({nm, " dout"}, {24'b0, mem_dout}, {24'b0, d[7:0]});
         end
         if (rob_done) begin got = c; break; end
      end
      check({nm, " lat"}, 32'(got), 32'(lat));
      @(posedge clk_in); #1;
      check({nm, " pulse"}, {31'b0, rob_done}, 32'd0);
   endtask

   task automatic do_load(input string nm, input logic [31:0] addr, input logic [2:0] w,
                          input logic sgn, input logic [31:0] exp, input int lat);
      int got;
      lb_en = 1'b1; lb_addr = addr; lb_width = w; lb_sgn = sgn;
      @(posedge clk_in); #1;
      got = -1;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk_in); #1;
         check({nm, " nowr"}, {31'b0, mem_wr}, 32'd0);
         if (lb_done) begin
            got = c;
            check({nm, " data"}, lb_data, exp);
            break;
         end
      end
      lb_en = 1'b0;
      check({nm, " lat"}, 32'(got), 32'(lat));
      @(posedge clk_in); #1;
      check({nm, " pulse"}, {31'b0, lb_done}, 32'd0);
   endtask

   typedef struct {
      logic        st;
      logic [31:0] addr;
      logic [2:0]  w;
      logic        sgn;
      logic [31:0] data;   // store data, or expected load result
      int          lat;
   } vec_t;

   vec_t vecs [14];

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int st_at, ld_at;

      vecs[0]  = '{1'b1, 32'h0000_0100, 3'b100, 1'b0, 32'hDEAD_BEEF, 5};
      vecs[1]  = '{1'b0, 32'h0000_0100, 3'b100, 1'b0, 32'hDEAD_BEEF, 6};
      vecs[2]  = '{1'b1, 32'h0000_0200, 3'b001, 1'b0, 32'h1234_5680, 2};
      vecs[3]  = '{1'b0, 32'h0000_0200, 3'b001, 1'b1, 32'hFFFF_FF80, 3};
      vecs[4]  = '{1'b0, 32'h0000_0200, 3'b001, 1'b0, 32'h0000_0080, 3};
      vecs[5]  = '{1'b1, 32'h0000_0300, 3'b010, 1'b0, 32'h0000_F00D, 3};
      vecs[6]  = '{1'b0, 32'h0000_0300, 3'b010, 1'b1, 32'hFFFF_F00D, 4};
      vecs[7]  = '{1'b0, 32'h0000_0300, 3'b010, 1'b0, 32'h0000_F00D, 4};
      vecs[8]  = '{1'b0, 32'h0000_0100, 3'b010, 1'b1, 32'hFFFF_BEEF, 4};
      vecs[9]  = '{1'b0, 32'h0000_0103, 3'b001, 1'b1, 32'hFFFF_FFDE, 3};
      vecs[10] = '{1'b1, 32'hFFFF_FFFF, 3'b010, 1'b0, 32'h0000_8001, 3};
      vecs[11] = '{1'b0, 32'hFFFF_FFFF, 3'b010, 1'b1, 32'hFFFF_8001, 4};
      vecs[12] = '{1'b1, 32'h0000_0400, 3'b010, 1'b0, 32'h1234_7F01, 3};
      vecs[13] = '{1'b0, 32'h0000_0400, 3'b010, 1'b1, 32'h0000_7F01, 4};

      rst_in = 1'b0; rdy_in = 1'b1; rob_rst_in = 1'b0;
      rob_en = 1'b0; rob_addr = '0; rob_width = '0; rob_data = '0;
      lb_en = 1'b0; lb_addr = '0; lb_width = '0; lb_sgn = 1'b0;
      repeat (3) @(posedge clk_in);
      #1;
      check("rst mem_a",    mem_a, 32'd0);
      check("rst mem_wr",   {31'b0, mem_wr}, 32'd0);
      check("rst mem_dout", {24'b0, mem_dout}, 32'd0);
      check("rst rob_done", {31'b0, rob_done}, 32'd0);
      check("rst lb_done",  {31'b0, lb_done}, 32'd0);
      check("rst lb_data",  lb_data, 32'd0);
      rst_in = 1'b1;
      @(posedge clk_in); #1;
      check("idle mem_wr", {31'b0, mem_wr}, 32'd0);

      for (int i = 0; i < 14; i++) begin
         if (vecs[i].st)
            do_store($sformatf("v%0d", i), vecs[i].addr, vecs[i].w, vecs[i].data, vecs[i].lat);
         else
            do_load($sformatf("v%0d", i), vecs[i].addr, vecs[i].w, vecs[i].sgn, vecs[i].data, vecs[i].lat);
      end
      check("sw ram 0x103", {24'b0, ram[12'h103]}, 32'h0000_00DE);
      check("wrap ram 0x000", {24'b0, ram[12'h000]}, 32'h0000_0080);

      // Store pulse arrives while a word load is in flight.
      lb_en = 1'b1; lb_addr = 32'h100; lb_width = 3'b100; lb_sgn = 1'b0;
      @(posedge clk_in); #1;
      ld_at = -1; st_at = -1;
      for (int e = 1; e <= 12; e++) begin
         @(posedge clk_in); #1;
         check("midst overlap", {31'b0, lb_done & rob_done}, 32'd0);
         if (lb_done) begin
            if (ld_at < 0) ld_at = e;
            check("midst ld data", lb_data, 32'hDEAD_BEEF);
            lb_en = 1'b0;
         end
         if (rob_done && st_at < 0) st_at = e;
         if (e == 7) begin
            check("midst st a",    mem_a, 32'h500);
            check("midst st dout", {24'b0, mem_dout}, 32'h5A);
            check("midst st wr",   {31'b0, mem_wr}, 32'd1);
         end
         if (e == 2) begin
            rob_en = 1'b1; rob_addr = 32'h500; rob_width = 3'b001; rob_data = 32'h5A;
         end
         if (e == 3) rob_en = 1'b0;
      end
      check("midst ld at", 32'(ld_at), 32'd6);
      check("midst st at", 32'(st_at), 32'd8);

      // Flush during the second byte of a halfword load.
      lb_en = 1'b1; lb_addr = 32'h300; lb_width = 3'b010; lb_sgn = 1'b1;
      @(posedge clk_in); #1;
      @(posedge clk_in); #1;
      check("flush ld a0", mem_a, 32'h300);
      @(posedge clk_in); #1;
      check("flush ld a1", mem_a, 32'h301);
      rob_rst_in = 1'b1;
      @(posedge clk_in); #1;
      rob_rst_in = 1'b0; lb_en = 1'b0;
      check("flush ld done", {31'b0, lb_done}, 32'd0);
      for (int e = 0; e < 4; e++) begin
         @(posedge clk_in); #1;
         check("flush quiet done", {31'b0, lb_done}, 32'd0);
         check("flush quiet a",    mem_a, 32'h301);
      end
      do_load("post flush lb", 32'h200, 3'b001, 1'b1, 32'hFFFF_FF80, 3);

      // Flush held during a halfword store across a 0x200 boundary.
      rob_rst_in = 1'b1;
      do_store("sh flush", 32'h1FF, 3'b010, 32'h0000_A55A, 3);
      rob_rst_in = 1'b0;
      check("sh flush ram 1ff", {24'b0, ram[12'h1FF]}, 32'h5A);
      check("sh flush ram 200", {24'b0, ram[12'h200]}, 32'hA5);
      do_load("sh flush lbu", 32'h200, 3'b001, 1'b0, 32'h0000_00A5, 3);

      // Store and load requested in the same idle cycle.
      rob_en = 1'b1; rob_addr = 32'h600; rob_width = 3'b001; rob_data = 32'h33;
      lb_en  = 1'b1; lb_addr  = 32'h600; lb_width  = 3'b001; lb_sgn  = 1'b0;
      @(posedge clk_in); #1;
      rob_en = 1'b0;
      ld_at = -1; st_at = -1;
      for (int e = 1; e <= 10; e++) begin
         @(posedge clk_in); #1;
         if (rob_done && st_at < 0) st_at = e;
         if (lb_done) begin
            if (ld_at < 0) ld_at = e;
            check("same ld data", lb_data, 32'h33);
            lb_en = 1'b0;
         end
      end
      check("same st at", 32'(st_at), 32'd2);
      check("same ld at", 32'(ld_at), 32'd5);

      // rdy_in low for three cycles in the middle of a word store.
      rob_en = 1'b1; rob_addr = 32'h700; rob_width = 3'b100; rob_data = 32'h4433_2211;
      @(posedge clk_in); #1;
      rob_en = 1'b0;
      @(posedge clk_in); #1;
      check("stall a0", mem_a, 32'h700);
      check("stall d0", {24'b0, mem_dout}, 32'h11);
      @(posedge clk_in); #1;
      check("stall a1", mem_a, 32'h701);
      check("stall d1", {24'b0, mem_dout}, 32'h22);
      rdy_in = 1'b0;
      for (int e = 0; e < 3; e++) begin
         @(posedge clk_in); #1;
         check("stall wr",   {31'b0, mem_wr}, 32'd0);
         check("stall hold", mem_a, 32'h701);
         check("stall done", {31'b0, rob_done}, 32'd0);
      end
      rdy_in = 1'b1;
      @(posedge clk_in); #1;
      check("stall a2", mem_a, 32'h702);
      check("stall d2", {24'b0, mem_dout}, 32'h33);
      check("stall wr2", {31'b0, mem_wr}, 32'd1);
      @(posedge clk_in); #1;
      check("stall a3", mem_a, 32'h703);
      check("stall d3", {24'b0, mem_dout}, 32'h44);
      @(posedge clk_in); #1;
      check("stall st done", {31'b0, rob_done}, 32'd1);
      @(posedge clk_in); #1;
      do_load("stall lw", 32'h700, 3'b100, 1'b0, 32'h4433_2211, 6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
